grayscale_stream_arbiter: RTL and testbench

GRAYSCALE_STREAM_ARBITER -- requirements
Module: grayscale_stream_arbiter

---
 rtl/grayscale_stream_arbiter_if.sv | 40 ++++
 rtl/grayscale_stream_arbiter.sv | 145 ++++++++++++++
 tb/tb_grayscale_stream_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/grayscale_stream_arbiter_if.sv
// Bundle of the two RGB input streams and the grayscale output stream.
// slave  : the arbiter's view (accepts the RGB streams, drives the output beat).
// master : the environment's view (drives the RGB streams, consumes the output).
interface grayscale_stream_arbiter_if;
    logic       s0_valid;
    logic       s0_ready;
    logic       s0_last;
    logic [7:0] s0_r;
    logic [7:0] s0_g;
    logic [7:0] s0_b;

    logic       s1_valid;
    logic       s1_ready;
    logic       s1_last;
    logic [7:0] s1_r;
    logic [7:0] s1_g;
    logic [7:0] s1_b;

    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_gray;
    logic       m_src;
    logic       m_last;

    modport slave (
        input  s0_valid, s0_last, s0_r, s0_g, s0_b,
        input  s1_valid, s1_last, s1_r, s1_g, s1_b,
        output s0_ready, s1_ready,
        output m_valid, m_gray, m_src, m_last,
        input  m_ready
    );

    modport master (
        output s0_valid, s0_last, s0_r, s0_g, s0_b,
        output s1_valid, s1_last, s1_r, s1_g, s1_b,
        input  s0_ready, s1_ready,
        input  m_valid, m_gray, m_src, m_last,
        output m_ready
    );
endinterface

// File: rtl/grayscale_stream_arbiter.sv
// Two RGB streams share one grayscale converter. Arbitration is per video
// line: once a stream wins, it keeps the datapath until its beat with last=1.
// Output stage is a single register slice (latency 1, full throughput).
// Optional macro GRAYSCALE_ARB_ROUND_ROBIN_EN: ties in IDLE go to the stream
// that did not finish the previous line; otherwise stream 0 always wins ties.
module grayscale_stream_arbiter (
    input  logic                        clk,
    input  logic                        resetn,
    grayscale_stream_arbiter_if.slave   bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOCK0 = 2'd1;
    localparam logic [1:0] LOCK1 = 2'd2;

    logic [1:0]  state_q,   state_d;
    logic        m_valid_q, m_valid_d;
    logic [7:0]  m_gray_q,  m_gray_d;
    logic        m_src_q,   m_src_d;
    logic        m_last_q,  m_last_d;
`ifdef GRAYSCALE_ARB_ROUND_ROBIN_EN
    logic        last_grant_q, last_grant_d;
`endif

    logic        tie_winner;
    logic        grant;
    logic        advance;
    logic        accept;
    logic        sel_valid;
    logic        sel_last;
    logic [7:0]  sel_r, sel_g, sel_b;
    logic [14:0] gray_sum;

    // Tie-break between two simultaneously valid streams while idle.
    always_comb begin
`ifdef GRAYSCALE_ARB_ROUND_ROBIN_EN
        tie_winner = ~last_grant_q;
`else
        tie_winner = 1'b0;
`endif
    end

    // Select the stream that owns the datapath this cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        grant = 1'b0;
        case (state_q)
            LOCK0:   grant = 1'b0;
            LOCK1:   grant = 1'b1;
            default: begin
                if (bus.s0_valid && bus.s1_valid) grant = tie_winner;
                else if (bus.s1_valid)            grant = 1'b1;
                else                              grant = 1'b0;
            end
        endcase
    end

    assign advance      = !m_valid_q || bus.m_ready;
    assign bus.s0_ready = advance && !grant;
    assign bus.s1_ready = advance &&  grant;

    // Mux the granted stream into the shared converter.
    always_comb begin
        sel_valid = bus.s0_valid;
        sel_last  = bus.s0_last;
        sel_r     = bus.s0_r;
        sel_g     = bus.s0_g;
        sel_b     = bus.s0_b;
        if (grant) begin
            sel_valid = bus.s1_valid;
            sel_last  = bus.s1_last;
            sel_r     = bus.s1_r;
            sel_g     = bus.s1_g;
            sel_b     = bus.s1_b;
        end
    end

    assign accept = advance && sel_valid;

    // Weights sum to 128, so the rounded result never exceeds 255.
    assign gray_sum = 15'd27 * {7'd0, sel_r}
                    + 15'd92 * {7'd0, sel_g}
                    + 15'd9  * {7'd0, sel_b}
                    + 15'd64;

    // Next-state: load the output slice on accept, drain it otherwise.
    always_comb begin
        state_d   = state_q;
        m_valid_d = m_valid_q;
        m_gray_d  = m_gray_q;
        m_src_d   = m_src_q;
        m_last_d  = m_last_q;
`ifdef GRAYSCALE_ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        if (accept) begin
            m_valid_d = 1'b1;
            m_gray_d  = gray_sum[14:7];
            m_src_d   = grant;
            m_last_d  = sel_last;
            if (sel_last) begin
                state_d = IDLE;
`ifdef GRAYSCALE_ARB_ROUND_ROBIN_EN
                last_grant_d = grant;
`endif
            end else begin
                state_d = grant ? LOCK1 : LOCK0;
            end
        end else if (bus.m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // State and output registers; reset discards any held beat or line lock.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            m_valid_q <= 1'b0;
            m_gray_q  <= 8'd0;
            m_src_q   <= 1'b0;
            m_last_q  <= 1'b0;
`ifdef GRAYSCALE_ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            state_q   <= state_d;
            m_valid_q <= m_valid_d;
            m_gray_q  <= m_gray_d;
            m_src_q   <= m_src_d;
            m_last_q  <= m_last_d;
`ifdef GRAYSCALE_ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign bus.m_valid = m_valid_q;
    assign bus.m_gray  = m_gray_q;
    assign bus.m_src   = m_src_q;
    assign bus.m_last  = m_last_q;

endmodule

// File: tb/tb_grayscale_stream_arbiter.sv
// Scoreboard bench for grayscale_stream_arbiter. A line-level reference model
// predicts readiness and output beats; a monitor pops and compares beats.
// Honors GRAYSCALE_ARB_ROUND_ROBIN_EN when defined for the build.
module tb_grayscale_stream_arbiter;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    grayscale_stream_arbiter_if bus_if ();

    grayscale_stream_arbiter dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        int gray;
        int src;
        int last;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    // Reference model state: which stream owns an unfinished line (-1 none),
    // who finished the last line, and whether the output slot holds a beat.
    int    owner    = -1;
    int    lg       = 1;
    bit    out_full = 1'b0;
    bit    xfer [2];

    // Random driver state per stream.
    bit    pend [2];
    int    left [2];

    function automatic int gray_of(int r, int g, int b);
        return (27 * r + 92 * g + 9 * b + 64) / 128;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_stream(input int k, input bit v, input bit l,
                              input int r, input int g, input int b);
        if (k == 0) begin
            bus_if.s0_valid = v; bus_if.s0_last = l;
            bus_if.s0_r = 8'(r); bus_if.s0_g = 8'(g); bus_if.s0_b = 8'(b);
        end else begin
            bus_if.s1_valid = v; bus_if.s1_last = l;
            bus_if.s1_r = 8'(r); bus_if.s1_g = 8'(g); bus_if.s1_b = 8'(b);
        end
    endtask

    task automatic idle_inputs();
        set_stream(0, 1'b0, 1'b0, 0, 0, 0);
        set_stream(1, 1'b0, 1'b0, 0, 0, 0);
    endtask

    // One cycle of the reference model, evaluated just before the rising edge.
    task automatic model_cycle();
        bit v [2];
        bit l [2];
        int r [2];
        int g [2];
        int b [2];
        bit adv;
        int grant;
        v[0] = bus_if.s0_valid; l[0] = bus_if.s0_last;
        r[0] = bus_if.s0_r; g[0] = bus_if.s0_g; b[0] = bus_if.s0_b;
        v[1] = bus_if.s1_valid; l[1] = bus_if.s1_last;
        r[1] = bus_if.s1_r; g[1] = bus_if.s1_g; b[1] = bus_if.s1_b;

        check("m_valid", int'(bus_if.m_valid), int'(out_full));
        adv = !out_full || bus_if.m_ready;
        if (owner >= 0) grant = owner;
        else if (v[0] && v[1]) begin
`ifdef GRAYSCALE_ARB_ROUND_ROBIN_EN
            grant = 1 - lg;
`else
            grant = 0;
`endif
        end
        else if (v[1]) grant = 1;
        else grant = 0;

        check("s0_ready", int'(bus_if.s0_ready), int'(adv && grant == 0));
        check("s1_ready", int'(bus_if.s1_ready), int'(adv && grant == 1));

        xfer[0] = adv && grant == 0 && v[0];
        xfer[1] = adv && grant == 1 && v[1];
        if (xfer[grant]) begin
            exp_q.push_back('{gray: gray_of(r[grant], g[grant], b[grant]),
                              src: grant, last: int'(l[grant])});
            if (l[grant]) begin
                owner = -1;
                lg    = grant;
            end else begin
                owner = grant;
            end
            out_full = 1'b1;
        end else if (bus_if.m_ready) begin
            out_full = 1'b0;
        end
    endtask

    // Called right after a falling edge with inputs already driven.
    task automatic step();
        #4;
        model_cycle();
        @(negedge clk);
    endtask

    task automatic reset_dut();
        idle_inputs();
        bus_if.m_ready = 1'b1;
        #2 resetn = 1'b0;
        #1;
        check("rst_m_valid", int'(bus_if.m_valid), 0);
        check("rst_m_gray",  int'(bus_if.m_gray),  0);
        check("rst_m_src",   int'(bus_if.m_src),   0);
        check("rst_m_last",  int'(bus_if.m_last),  0);
        owner    = -1;
        lg       = 1;
        out_full = 1'b0;
        exp_q.delete();
        pend[0] = 1'b0; pend[1] = 1'b0;
        left[0] = 0;    left[1] = 0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // Monitor: pops expected beats on output transfers, checks hold stability.
    initial begin : monitor
        bit   held = 1'b0;
        logic [7:0] h_gray;
        logic h_src, h_last;
        beat_t e;
        forever begin
            @(negedge clk);
            #4;
            if (!resetn) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("hold_valid", int'(bus_if.m_valid), 1);
                    check("hold_gray",  int'(bus_if.m_gray),  int'(h_gray));
                    check("hold_src",   int'(bus_if.m_src),   int'(h_src));
                    check("hold_last",  int'(bus_if.m_last),  int'(h_last));
                end
                if (bus_if.m_valid && bus_if.m_ready) begin
                    held = 1'b0;
                    check("sb_nonempty", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("out_gray", int'(bus_if.m_gray), e.gray);
                        check("out_src",  int'(bus_if.m_src),  e.src);
                        check("out_last", int'(bus_if.m_last), e.last);
                    end
                end else if (bus_if.m_valid) begin
                    held   = 1'b1;
                    h_gray = bus_if.m_gray;
                    h_src  = bus_if.m_src;
                    h_last = bus_if.m_last;
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    initial begin : stimulus
        int seq27 [4];
        int seq28 [4];
`ifdef GRAYSCALE_ARB_ROUND_ROBIN_EN
        seq27 = '{0, 1, 0, 1};
`else
        seq27 = '{0, 0, 0, 0};
`endif
        seq28 = '{0, 0, 0, 1};
        idle_inputs();
        bus_if.m_ready = 1'b1;
        @(negedge clk);

        // White pixel from stream 0, transferred on the first edge after reset.
        reset_dut();
        set_stream(0, 1'b1, 1'b1, 255, 255, 255);
        step();
        check("white_valid", int'(bus_if.m_valid), 1);
        check("white_gray",  int'(bus_if.m_gray),  255);
        check("white_src",   int'(bus_if.m_src),   0);
        check("white_last",  int'(bus_if.m_last),  1);

        // Stream 1 colour and black pixels.
        idle_inputs();
        set_stream(1, 1'b1, 1'b1, 100, 50, 200);
        step();
        check("color_gray", int'(bus_if.m_gray), 71);
        check("color_src",  int'(bus_if.m_src),  1);
        set_stream(1, 1'b1, 1'b1, 0, 0, 0);
        step();
        check("black_gray", int'(bus_if.m_gray), 0);
        idle_inputs();
        step();

        // Both streams always valid with single-beat lines.
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            set_stream(0, 1'b1, 1'b1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
            set_stream(1, 1'b1, 1'b1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
            step();
            check($sformatf("tie_seq%0d_src", i), int'(bus_if.m_src), seq27[i]);
        end
        idle_inputs();
        step();

        // Three-beat line on stream 0 locks out a waiting stream 1.
        reset_dut();
        set_stream(1, 1'b1, 1'b1, 5, 5, 5);
        for (int i = 0; i < 4; i++) begin
            if (i < 3) set_stream(0, 1'b1, i == 2, 10 * i, 20 * i, 30 * i);
            else       set_stream(0, 1'b0, 1'b0, 0, 0, 0);
            step();
            check($sformatf("line_seq%0d_src", i), int'(bus_if.m_src), seq28[i]);
        end
        idle_inputs();
        step();

        // Backpressure for four cycles, then release with a new beat waiting.
        reset_dut();
        set_stream(0, 1'b1, 1'b1, 10, 20, 30);
        step();
        set_stream(0, 1'b1, 1'b1, 40, 50, 60);
        set_stream(1, 1'b1, 1'b1, 7, 8, 9);
        bus_if.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        bus_if.m_ready = 1'b1;
        step();
        check("bp_release_valid", int'(bus_if.m_valid), 1);
        idle_inputs();
        step();
        step();

        // Reset in the middle of a stream-1 line.
        reset_dut();
        set_stream(1, 1'b1, 1'b0, 1, 2, 3);
        step();
        set_stream(1, 1'b1, 1'b0, 4, 5, 6);
        step();
        reset_dut();
        set_stream(0, 1'b1, 1'b1, 11, 22, 33);
        set_stream(1, 1'b1, 1'b1, 44, 55, 66);
        step();
        check("post_rst_tie_src", int'(bus_if.m_src), 0);
        idle_inputs();
        step();

        // Randomized traffic with random line lengths and backpressure.
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!pend[k]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        if (left[k] == 0) left[k] = $urandom_range(1, 4);
                        set_stream(k, 1'b1, left[k] == 1, $urandom_range(0, 255),
                                   $urandom_range(0, 255), $urandom_range(0, 255));
                        pend[k] = 1'b1;
                    end else begin
                        set_stream(k, 1'b0, 1'b0, 0, 0, 0);
                    end
                end
            end
            bus_if.m_ready = ($urandom_range(0, 3) != 0);
            step();
            for (int k = 0; k < 2; k++) begin
                if (xfer[k]) begin
                    pend[k] = 1'b0;
                    left[k] = left[k] - 1;
                end
            end
        end

        // Drain and confirm every predicted beat came out.
        idle_inputs();
        bus_if.m_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
